// File: rtl/ps2_text_line_if.sv
// Keyboard-code and pixel-scan bundle between the PS/2 line editor and the VGA text overlay.
interface ps2_text_line_if #(
  parameter int MAX_CHARS = 16
);
  localparam int CW = $clog2(MAX_CHARS + 1);

  logic [7:0]    PS2_code;
  logic          PS2_code_ready;
  logic          PS2_make_code;
  logic [9:0]    pixel_X_pos;
  logic [9:0]    pixel_Y_pos;
  logic [5:0]    character_address;
  logic          line_active;
  logic [CW-1:0] char_count;
  logic          line_full;

  modport master (
    output PS2_code, PS2_code_ready, PS2_make_code, pixel_X_pos, pixel_Y_pos,
    input  character_address, line_active, char_count, line_full
  );

  modport slave (
    input  PS2_code, PS2_code_ready, PS2_make_code, pixel_X_pos, pixel_Y_pos,
    output character_address, line_active, char_count, line_full
  );
endinterface

// File: rtl/ps2_text_line.sv
// Editable one-line text buffer fed by PS/2 make codes; supplies char_rom addresses
// for the pixel currently being scanned.
module ps2_text_line #(
  parameter int MAX_CHARS   = 16,
  parameter int LINE_Y      = 320,
  parameter int START_X     = 360,
  parameter int SCROLL_MODE = 1
) (
  input  logic           CLOCK_50_I,
  input  logic           resetn,
  ps2_text_line_if.slave bus
);
  localparam int         CW    = $clog2(MAX_CHARS + 1);
  localparam int         IW    = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
  localparam logic [5:0] SPACE = 6'o40;
  localparam logic [6:0] ROW   = 7'(LINE_Y >> 3);
  localparam logic [6:0] COL0  = 7'(START_X >> 3);

  logic          ready_buf;
  logic [CW-1:0] count;
  logic [5:0]    slots [MAX_CHARS];
  logic          key_event;
  logic          is_print;
  logic [5:0]    key_char;
  logic          full;
  logic [6:0]    col;
  logic [IW-1:0] idx;
  logic          active;

  assign key_event = bus.PS2_code_ready & ~ready_buf & bus.PS2_make_code;
  assign full      = (count == CW'(MAX_CHARS));

  always_comb begin
    is_print = 1'b1;
    key_char = SPACE;
    case (bus.PS2_code)
      8'h45: key_char = 6'o60;  8'h16: key_char = 6'o61;
      8'h1E: key_char = 6'o62;  8'h26: key_char = 6'o63;
      8'h25: key_char = 6'o64;  8'h2E: key_char = 6'o65;
      8'h36: key_char = 6'o66;  8'h3D: key_char = 6'o67;
      8'h3E: key_char = 6'o70;  8'h46: key_char = 6'o71;
      8'h1C: key_char = 6'o01;  8'h32: key_char = 6'o02;
      8'h21: key_char = 6'o03;  8'h23: key_char = 6'o04;
      8'h24: key_char = 6'o05;  8'h2B: key_char = 6'o06;
      8'h34: key_char = 6'o07;  8'h33: key_char = 6'o10;
      8'h43: key_char = 6'o11;  8'h3B: key_char = 6'o12;
      8'h42: key_char = 6'o13;  8'h4B: key_char = 6'o14;
      8'h3A: key_char = 6'o15;  8'h31: key_char = 6'o16;
      8'h44: key_char = 6'o17;  8'h4D: key_char = 6'o20;
      8'h15: key_char = 6'o21;  8'h2D: key_char = 6'o22;
      8'h1B: key_char = 6'o23;  8'h2C: key_char = 6'o24;
      8'h3C: key_char = 6'o25;  8'h2A: key_char = 6'o26;
      8'h1D: key_char = 6'o27;  8'h22: key_char = 6'o30;
      8'h35: key_char = 6'o31;  8'h1A: key_char = 6'o32;
      8'h29: key_char = SPACE;
      default: is_print = 1'b0;
    endcase
  end

  // Slots at or beyond count are kept as spaces so the display needs no count compare.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      ready_buf <= 1'b0;
      count     <= '0;
      for (int i = 0; i < MAX_CHARS; i++) slots[i] <= SPACE;
    end else begin
      ready_buf <= bus.PS2_code_ready;
      if (key_event) begin
        if (bus.PS2_code == 8'h5A) begin
          for (int i = 0; i < MAX_CHARS; i++) slots[i] <= SPACE;
          count <= '0;
        end else if (bus.PS2_code == 8'h66) begin
          if (count != '0) begin
            for (int i = 0; i < MAX_CHARS; i++)
              if (i == int'(count) - 1) slots[i] <= SPACE;
            count <= count - 1'b1;
          end
        end else if (is_print) begin
          if (!full) begin
            for (int i = 0; i < MAX_CHARS; i++)
              if (i == int'(count)) slots[i] <= key_char;
            count <= count + 1'b1;
          end else if (SCROLL_MODE != 0) begin
            for (int i = 0; i < MAX_CHARS - 1; i++) slots[i] <= slots[i+1];
            slots[MAX_CHARS-1] <= key_char;
          end
        end
      end
    end
  end

  // Wrapping 7-bit subtract makes columns left of START_X look huge, hence inactive.
  assign col    = bus.pixel_X_pos[9:3] - COL0;
  assign idx    = col[IW-1:0];
  assign active = (bus.pixel_Y_pos[9:3] == ROW) && (col < 7'(MAX_CHARS));

  assign bus.line_active       = active;
  assign bus.character_address = active ? slots[idx] : SPACE;
  assign bus.char_count        = count;
  assign bus.line_full         = full;
endmodule

// File: tb/tb_ps2_text_line.sv
// Drives three line editors (16-wide scrolling, 4-wide scrolling, 4-wide holding) with the
// same keystrokes and checks them against queue-based models through a scoreboard.
module tb_ps2_text_line;
  typedef logic [5:0] chq_t[$];
  typedef struct {
    string      tag;
    int         src;
    logic [6:0] exp;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] code;
  logic       ready;
  logic       make;
  logic [9:0] px;
  logic [9:0] py;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  chq_t m16, m4s, m4h;

  always #10 clk = ~clk;

  ps2_text_line_if #(.MAX_CHARS(16)) bus16 ();
  ps2_text_line_if #(.MAX_CHARS(4))  bus4s ();
  ps2_text_line_if #(.MAX_CHARS(4))  bus4h ();

  assign bus16.PS2_code = code;  assign bus16.PS2_code_ready = ready;  assign bus16.PS2_make_code = make;
  assign bus4s.PS2_code = code;  assign bus4s.PS2_code_ready = ready;  assign bus4s.PS2_make_code = make;
  assign bus4h.PS2_code = code;  assign bus4h.PS2_code_ready = ready;  assign bus4h.PS2_make_code = make;
  assign bus16.pixel_X_pos = px; assign bus16.pixel_Y_pos = py;
  assign bus4s.pixel_X_pos = px; assign bus4s.pixel_Y_pos = py;
  assign bus4h.pixel_X_pos = px; assign bus4h.pixel_Y_pos = py;

  ps2_text_line #(.MAX_CHARS(16), .LINE_Y(320), .START_X(360), .SCROLL_MODE(1)) dut16 (
    .CLOCK_50_I(clk), .resetn(resetn), .bus(bus16));
  ps2_text_line #(.MAX_CHARS(4), .LINE_Y(320), .START_X(360), .SCROLL_MODE(1)) dut4s (
    .CLOCK_50_I(clk), .resetn(resetn), .bus(bus4s));
  ps2_text_line #(.MAX_CHARS(4), .LINE_Y(320), .START_X(360), .SCROLL_MODE(0)) dut4h (
    .CLOCK_50_I(clk), .resetn(resetn), .bus(bus4h));

  // Returns {printable, char_rom address} for a set-2 make code.
  function automatic logic [6:0] xlate(logic [7:0] k);
    case (k)
      8'h45: return 7'o160; 8'h16: return 7'o161; 8'h1E: return 7'o162; 8'h26: return 7'o163;
      8'h25: return 7'o164; 8'h2E: return 7'o165; 8'h36: return 7'o166; 8'h3D: return 7'o167;
      8'h3E: return 7'o170; 8'h46: return 7'o171; 8'h1C: return 7'o101; 8'h32: return 7'o102;
      8'h21: return 7'o103; 8'h23: return 7'o104; 8'h24: return 7'o105; 8'h2B: return 7'o106;
      8'h34: return 7'o107; 8'h33: return 7'o110; 8'h43: return 7'o111; 8'h3B: return 7'o112;
      8'h42: return 7'o113; 8'h4B: return 7'o114; 8'h3A: return 7'o115; 8'h31: return 7'o116;
      8'h44: return 7'o117; 8'h4D: return 7'o120; 8'h15: return 7'o121; 8'h2D: return 7'o122;
      8'h1B: return 7'o123; 8'h2C: return 7'o124; 8'h3C: return 7'o125; 8'h2A: return 7'o126;
      8'h1D: return 7'o127; 8'h22: return 7'o130; 8'h35: return 7'o131; 8'h1A: return 7'o132;
      8'h29: return 7'o140;
      default: return 7'o000;
    endcase
  endfunction

  function automatic chq_t apply_model(chq_t q, int maxc, bit scroll, logic [7:0] k);
    chq_t       r;
    logic [6:0] t;
    r = q;
    t = xlate(k);
    if (k == 8'h5A) r.delete();
    else if (k == 8'h66) begin
      if (r.size() > 0) void'(r.pop_back());
    end else if (t[6]) begin
      if (r.size() < maxc) r.push_back(t[5:0]);
      else if (scroll) begin
        void'(r.pop_front());
        r.push_back(t[5:0]);
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] slot_of(chq_t q, int i);
    return (i < q.size()) ? {1'b0, q[i]} : 7'o040;
  endfunction

  function automatic logic [6:0] observe(int src);
    case (src)
      0: return 7'(bus16.char_count);
      1: return 7'(bus4s.char_count);
      2: return 7'(bus4h.char_count);
      3: return {6'd0, bus16.line_full};
      4: return {6'd0, bus4s.line_full};
      5: return {6'd0, bus4h.line_full};
      6: return {1'b0, bus16.character_address};
      7: return {1'b0, bus4s.character_address};
      8: return {1'b0, bus4h.character_address};
      9: return {6'd0, bus16.line_active};
      10: return {6'd0, bus4s.line_active};
      11: return {6'd0, bus4h.line_active};
      default: return 7'bx;
    endcase
  endfunction

  task automatic expect_val(string tag, int src, logic [6:0] v);
    exp_t e;
    e.tag = tag;
    e.src = src;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_output();
    exp_t       e;
    logic [6:0] got;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = observe(e.src);
      tests++;
      assert (got === e.exp) else begin
        fails++;
        $error("[TB] FAIL %s: observed %0o expected %0o", e.tag, got, e.exp);
      end
    end
  endtask

  task automatic model_all(logic [7:0] k);
    m16 = apply_model(m16, 16, 1'b1, k);
    m4s = apply_model(m4s, 4, 1'b1, k);
    m4h = apply_model(m4h, 4, 1'b0, k);
  endtask

  task automatic push_counts(string tag);
    expect_val({tag, ".cnt16"}, 0, 7'(m16.size()));
    expect_val({tag, ".cnt4s"}, 1, 7'(m4s.size()));
    expect_val({tag, ".cnt4h"}, 2, 7'(m4h.size()));
    expect_val({tag, ".full16"}, 3, 7'(m16.size() == 16));
    expect_val({tag, ".full4s"}, 4, 7'(m4s.size() == 4));
    expect_val({tag, ".full4h"}, 5, 7'(m4h.size() == 4));
  endtask

  task automatic pulse(logic [7:0] k, logic mk);
    @(negedge clk);
    code  = k;
    make  = mk;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  // One keystroke: make pulse, then the F0 prefix and the break code, which must be inert.
  task automatic apply_stimulus(logic [7:0] k);
    string tag;
    tag = $sformatf("key%02h", k);
    pulse(k, 1'b1);
    model_all(k);
    push_counts(tag);
    check_output();
    pulse(8'hF0, 1'b0);
    pulse(k, 1'b0);
    push_counts({tag, ".brk"});
    check_output();
  endtask

  task automatic check_line(string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      px = 10'(360 + 8 * i + (i % 8));
      py = 10'(320 + (i % 8));
      #1;
      expect_val($sformatf("%s.addr16[%0d]", tag, i), 6, slot_of(m16, i));
      expect_val($sformatf("%s.act16[%0d]", tag, i), 9, 7'd1);
      expect_val($sformatf("%s.addr4s[%0d]", tag, i), 7, (i < 4) ? slot_of(m4s, i) : 7'o040);
      expect_val($sformatf("%s.act4s[%0d]", tag, i), 10, 7'(i < 4));
      expect_val($sformatf("%s.addr4h[%0d]", tag, i), 8, (i < 4) ? slot_of(m4h, i) : 7'o040);
      expect_val($sformatf("%s.act4h[%0d]", tag, i), 11, 7'(i < 4));
      check_output();
    end
  endtask

  task automatic check_outside(string tag, logic [9:0] x, logic [9:0] y);
    @(negedge clk);
    px = x;
    py = y;
    #1;
    for (int s = 0; s < 3; s++) begin
      expect_val($sformatf("%s.addr%0d", tag, s), 6 + s, 7'o040);
      expect_val($sformatf("%s.act%0d", tag, s), 9 + s, 7'd0);
    end
    check_output();
  endtask

  initial begin
    resetn = 1'b0;
    code   = 8'h00;
    ready  = 1'b0;
    make   = 1'b0;
    px     = 10'd360;
    py     = 10'd320;
    #3;
    push_counts("reset");
    check_output();
    check_line("reset");
    @(negedge clk);
    resetn = 1'b1;

    apply_stimulus(8'h16);
    apply_stimulus(8'h1E);
    apply_stimulus(8'h26);
    check_line("digits");
    check_outside("right_end", 10'd488, 10'd320);

    // A level held high must yield exactly one stored character.
    @(negedge clk);
    code  = 8'h1C;
    make  = 1'b1;
    ready = 1'b1;
    repeat (100) @(negedge clk);
    ready = 1'b0;
    model_all(8'h1C);
    push_counts("hold");
    check_output();
    check_line("hold");

    apply_stimulus(8'h76);
    apply_stimulus(8'h5A);
    check_line("enter1");

    apply_stimulus(8'h1C);
    apply_stimulus(8'h32);
    apply_stimulus(8'h66);
    check_line("bksp1");
    apply_stimulus(8'h66);
    apply_stimulus(8'h66);
    check_line("bksp3");

    apply_stimulus(8'h1C);
    apply_stimulus(8'h32);
    apply_stimulus(8'h21);
    apply_stimulus(8'h23);
    apply_stimulus(8'h24);
    check_line("overflow");

    apply_stimulus(8'h5A);
    apply_stimulus(8'h29);
    apply_stimulus(8'h1C);
    apply_stimulus(8'h45);
    check_line("three");
    apply_stimulus(8'h5A);
    check_line("enter2");

    apply_stimulus(8'h16);
    apply_stimulus(8'h1E);
    @(negedge clk);
    code   = 8'h26;
    make   = 1'b1;
    ready  = 1'b1;
    #5;
    resetn = 1'b0;
    #1;
    m16.delete();
    m4s.delete();
    m4h.delete();
    push_counts("midreset");
    check_output();
    ready = 1'b0;
    check_line("midreset");
    check_outside("left_of_line", 10'd352, 10'd320);
    check_outside("below_line", 10'd360, 10'd328);
    @(negedge clk);
    resetn = 1'b1;
    apply_stimulus(8'h45);
    check_line("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
